// File: rtl/exec_mem_unit.sv
// exec_mem_unit: EX-stage ALU, fetch PC+4 adder and
// big-endian byte-addressed MEM-stage data memory.
module exec_mem_unit #(
  parameter int MEM_BYTES = 512,
  parameter int DATA_W    = 32,
  localparam int AW       = $clog2(MEM_BYTES),
  localparam int SW       = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_z,
  output logic              alu_n,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_plus4,
  input  logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_di,
  input  logic [1:0]        mem_size,
  input  logic              mem_rw,
  input  logic              mem_en,
  input  logic              mem_se,
  output logic [DATA_W-1:0] mem_do
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_PA   = 4'b1011;
  localparam logic [3:0] OP_PB   = 4'b1100;
  localparam logic [3:0] OP_B8   = 4'b1101;

  localparam int ZW = DATA_W - 1;
  localparam int HW = DATA_W - 16;
  localparam int BW = DATA_W - 8;

  logic [SW-1:0] shamt;
  logic          lt_s;
  logic          lt_u;

  assign shamt = alu_a[SW-1:0];
  assign lt_s  = $signed(alu_a) < $signed(alu_b);
  assign lt_u  = alu_a < alu_b;

  // ALU result select; shifts use B as data and A as amount
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      OP_SLL:  alu_out = alu_b << shamt;
      OP_SRL:  alu_out = alu_b >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(alu_b) >>> shamt);
      OP_SLT:  alu_out = {{ZW{1'b0}}, lt_s};
      OP_SLTU: alu_out = {{ZW{1'b0}}, lt_u};
      OP_PA:   alu_out = alu_a;
      OP_PB:   alu_out = alu_b;
      OP_B8:   alu_out = alu_b + DATA_W'(8);
      default: alu_out = '0;
    endcase
  end

  assign alu_z    = (alu_out == '0);
  assign alu_n    = alu_out[DATA_W-1];
  assign pc_plus4 = pc_in + DATA_W'(4);

  logic [7:0] mem [0:MEM_BYTES-1];

  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;

  // consecutive byte addresses wrap at the end of the array
  assign a0 = mem_addr;
  assign a1 = mem_addr + AW'(1);
  assign a2 = mem_addr + AW'(2);
  assign a3 = mem_addr + AW'(3);

  logic sz_byte;
  logic sz_half;
  logic sz_word;

  // size 11 is folded into word
  assign sz_byte = (mem_size == 2'b00);
  assign sz_half = (mem_size == 2'b01);
  assign sz_word = mem_size[1];

  logic rd_en;
  logic wr_en;

  assign rd_en = mem_en & ~mem_rw & ~reset;
  assign wr_en = mem_en &  mem_rw & ~reset;

  logic [7:0] rb0;
  logic [7:0] rb1;
  logic [7:0] rb2;
  logic [7:0] rb3;

  assign rb0 = mem[a0];
  assign rb1 = mem[a1];
  assign rb2 = mem[a2];
  assign rb3 = mem[a3];

  logic hs;
  logic bs;

  assign hs = mem_se & rb0[7];
  assign bs = mem_se & rb0[7];

  // combinational big-endian read with optional sign extension
  always_comb begin
    mem_do = '0;
    if (rd_en) begin
      unique case (1'b1)
        sz_word: mem_do = {rb0, rb1, rb2, rb3};
        sz_half: mem_do = {{HW{hs}}, rb0, rb1};
        sz_byte: mem_do = {{BW{bs}}, rb0};
        default: mem_do = '0;
      endcase
    end
  end

  // big-endian store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      unique case (1'b1)
        sz_word: begin
          mem[a0] <= mem_di[31:24];
          mem[a1] <= mem_di[23:16];
          mem[a2] <= mem_di[15:8];
          mem[a3] <= mem_di[7:0];
        end
        sz_half: begin
          mem[a0] <= mem_di[15:8];
          mem[a1] <= mem_di[7:0];
        end
        sz_byte: begin
          mem[a0] <= mem_di[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: directed plus random stimulus with
// a queue scoreboard and a behavioural reference model.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        alu_n;
  logic [31:0] pc_in;
  logic [31:0] pc_plus4;
  logic [8:0]  mem_addr;
  logic [31:0] mem_di;
  logic [1:0]  mem_size;
  logic        mem_rw;
  logic        mem_en;
  logic        mem_se;
  logic [31:0] mem_do;

  always #5 clk = ~clk;

  exec_mem_unit dut (
    .clk(clk),
    .reset(reset),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_out(alu_out),
    .alu_z(alu_z),
    .alu_n(alu_n),
    .pc_in(pc_in),
    .pc_plus4(pc_plus4),
    .mem_addr(mem_addr),
    .mem_di(mem_di),
    .mem_size(mem_size),
    .mem_rw(mem_rw),
    .mem_en(mem_en),
    .mem_se(mem_se),
    .mem_do(mem_do)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl [0:511];

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sh = longint'(a[4:0]);
    longint d  = longint'(1) << sh;
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q;
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return 32'(ub * d);
      4'd7:  return 32'(ub / d);
      4'd8: begin
        if (sb >= 0) q = sb / d;
        else q = -((-sb + d - 1) / d);
        return 32'(q);
      end
      4'd9:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd10: return (ua < ub) ? 32'd1 : 32'd0;
      4'd11: return a;
      4'd12: return b;
      4'd13: return 32'(ub + 8);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(
    input logic [8:0] a,
    input logic [1:0] sz,
    input logic se
  );
    int n = nbytes(sz);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++)
      v = (v << 8) | {24'b0, mdl[(int'(a) + k) % 512]};
    if (se && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_write(
    input logic [8:0] a,
    input logic [1:0] sz,
    input logic [31:0] di
  );
    int n = nbytes(sz);
    for (int k = 0; k < n; k++)
      mdl[(int'(a) + k) % 512] = 8'(di >> (8 * (n - 1 - k)));
  endtask

  task automatic push(
    input string nm,
    input int kind,
    input logic [31:0] e
  );
    exp_t x;
    x.name = nm;
    x.kind = kind;
    x.exp  = e;
    sbq.push_back(x);
  endtask

  task automatic exp_alu(input string nm, input logic [31:0] e);
    push({nm, ".out"}, 0, e);
    push({nm, ".z"}, 1, {31'b0, e == 32'd0});
    push({nm, ".n"}, 2, {31'b0, e[31]});
  endtask

  task automatic exp_do(input string nm, input logic [31:0] e);
    push({nm, ".do"}, 4, e);
  endtask

  task automatic exp_model(input string nm);
    logic [31:0] rd;
    rd = (mem_en && !mem_rw && !reset)
       ? ref_read(mem_addr, mem_size, mem_se) : 32'd0;
    exp_alu(nm, ref_alu(alu_op, alu_a, alu_b));
    push({nm, ".pc"}, 3, 32'(longint'({32'b0, pc_in}) + 4));
    exp_do(nm, rd);
  endtask

  task automatic aset(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
  endtask

  task automatic mset(
    input logic en,
    input logic rw,
    input logic [1:0] sz,
    input logic se,
    input logic [8:0] ad,
    input logic [31:0] di
  );
    mem_en   = en;
    mem_rw   = rw;
    mem_size = sz;
    mem_se   = se;
    mem_addr = ad;
    mem_di   = di;
  endtask

  task automatic tick();
    @(posedge clk);
    if (mem_en && mem_rw && !reset)
      ref_write(mem_addr, mem_size, mem_di);
    #1;
  endtask

  task automatic rd(
    input string nm,
    input logic [1:0] sz,
    input logic se,
    input logic [8:0] ad,
    input logic [31:0] e
  );
    mset(1'b1, 1'b0, sz, se, ad, 32'd0);
    exp_do(nm, e);
    tick();
  endtask

  // scoreboard monitor: compares away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sbq.pop_front();
        case (e.kind)
          0: act = alu_out;
          1: act = {31'b0, alu_z};
          2: act = {31'b0, alu_n};
          3: act = pc_plus4;
          default: act = mem_do;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    pc_in = 32'd0;
    aset(4'b0000, 32'd0, 32'd0);
    mset(1'b0, 1'b0, 2'b10, 1'b0, 9'd0, 32'd0);
    @(posedge clk);
    #1;

    aset(4'b1111, 32'h1234, 32'h5678);
    mset(1'b1, 1'b0, 2'b10, 1'b0, 9'd8, 32'd0);
    exp_alu("rst_op15", 32'd0);
    exp_do("rst_rd", 32'd0);
    push("pc0.pc", 3, 32'd4);
    tick();
    reset = 1'b0;

    aset(4'b0001, 32'd5, 32'd5);
    exp_alu("sub_eq", 32'd0);
    tick();
    aset(4'b0001, 32'd3, 32'd5);
    exp_alu("sub_neg", 32'hFFFF_FFFE);
    tick();
    aset(4'b0000, 32'hFFFF_FFFF, 32'd1);
    exp_alu("add_wrap", 32'd0);
    tick();
    aset(4'b0111, 32'd4, 32'h8000_0000);
    exp_alu("srl", 32'h0800_0000);
    tick();
    aset(4'b1000, 32'd4, 32'h8000_0000);
    exp_alu("sra", 32'hF800_0000);
    tick();
    aset(4'b0110, 32'd4, 32'h8000_0000);
    exp_alu("sll", 32'd0);
    tick();
    aset(4'b1001, 32'hFFFF_FFFF, 32'd1);
    exp_alu("slt", 32'd1);
    tick();
    aset(4'b1010, 32'hFFFF_FFFF, 32'd1);
    exp_alu("sltu", 32'd0);
    tick();
    aset(4'b1101, 32'd7, 32'd100);
    exp_alu("b8", 32'd108);
    tick();
    aset(4'b1111, 32'd9, 32'd9);
    exp_alu("op15", 32'd0);
    pc_in = 32'hFFFF_FFFC;
    push("pcwrap.pc", 3, 32'd0);
    tick();

    mset(1'b1, 1'b1, 2'b10, 1'b0, 9'd8, 32'hA1B2_C3D4);
    exp_do("wr_do", 32'd0);
    tick();
    rd("w8", 2'b10, 1'b0, 9'd8, 32'hA1B2_C3D4);
    rd("w8se", 2'b10, 1'b1, 9'd8, 32'hA1B2_C3D4);
    rd("b8z", 2'b00, 1'b0, 9'd8, 32'h0000_00A1);
    rd("b8s", 2'b00, 1'b1, 9'd8, 32'hFFFF_FFA1);
    rd("h10s", 2'b01, 1'b1, 9'd10, 32'hFFFF_C3D4);
    rd("h10z", 2'b01, 1'b0, 9'd10, 32'h0000_C3D4);
    rd("w8sz3", 2'b11, 1'b1, 9'd8, 32'hA1B2_C3D4);

    mset(1'b1, 1'b1, 2'b00, 1'b0, 9'd9, 32'hFFFF_FF5A);
    tick();
    rd("bw9", 2'b10, 1'b0, 9'd8, 32'hA15A_C3D4);

    reset = 1'b1;
    mset(1'b1, 1'b1, 2'b10, 1'b0, 9'd8, 32'h0BAD_F00D);
    exp_do("rstwr", 32'd0);
    tick();
    mset(1'b1, 1'b0, 2'b10, 1'b0, 9'd8, 32'd0);
    exp_do("rstrd", 32'd0);
    tick();
    reset = 1'b0;
    rd("after_rst", 2'b10, 1'b0, 9'd8, 32'hA15A_C3D4);

    mset(1'b0, 1'b1, 2'b10, 1'b0, 9'd8, 32'h0BAD_F00D);
    exp_do("en0wr", 32'd0);
    tick();
    mset(1'b0, 1'b0, 2'b10, 1'b0, 9'd8, 32'd0);
    exp_do("en0rd", 32'd0);
    tick();
    rd("after_en0", 2'b10, 1'b0, 9'd8, 32'hA15A_C3D4);

    mset(1'b1, 1'b1, 2'b10, 1'b0, 9'd510, 32'h1122_3344);
    tick();
    rd("m510", 2'b00, 1'b0, 9'd510, 32'h11);
    rd("m511", 2'b00, 1'b0, 9'd511, 32'h22);
    rd("m0", 2'b00, 1'b0, 9'd0, 32'h33);
    rd("m1", 2'b00, 1'b0, 9'd1, 32'h44);
    rd("w510", 2'b10, 1'b0, 9'd510, 32'h1122_3344);
    rd("h511", 2'b01, 1'b0, 9'd511, 32'h2233);

    for (int i = 0; i < 128; i++) begin
      mset(1'b1, 1'b1, 2'b10, 1'b0, 9'(4 * i), $urandom);
      tick();
    end

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0)
        a = a & 32'h0000_001F;
      aset(4'($urandom_range(0, 15)), a, b);
      pc_in = ($urandom_range(0, 7) == 0)
            ? 32'hFFFF_FFFC : $urandom;
      reset = ($urandom_range(0, 15) == 0);
      mset(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           9'($urandom_range(0, 511)),
           $urandom);
      exp_model("rnd");
      tick();
    end

    reset = 1'b0;
    mset(1'b0, 1'b0, 2'b10, 1'b0, 9'd0, 32'd0);
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Combined datapath block for the 5-stage pipelined CPU. It holds three functions:
  - the EX-stage 32-bit ALU with Z and N flags;
  - the fetch-path PC+4 adder;
  - a 512-byte big-endian data memory used in the MEM stage.
- The ALU and the adder are purely combinational.
- The memory reads combinationally and writes synchronously.

Parameters:
- MEM_BYTES, 512, number of byte locations in the data memory. Address width is log2(MEM_BYTES) = 9.
- DATA_W, 32, width of the ALU operands, the ALU result, the PC and the memory data ports.

Ports:
- clk  input  1  system clock; memory writes occur on its rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_a  input  32  ALU operand A.
- alu_b  input  32  ALU operand B.
- alu_op  input  4  ALU operation select.
- alu_out  output  32  ALU result.
- alu_z  output  1  zero flag: 1 when alu_out == 0.
- alu_n  output  1  negative flag: equals alu_out[31].
- pc_in  input  32  current PC.
- pc_plus4  output  32  pc_in + 4.
- mem_addr  input  9  byte address.
- mem_di  input  32  write data.
- mem_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- mem_rw  input  1  0 = read, 1 = write.
- mem_en  input  1  memory enable.
- mem_se  input  1  sign-extend byte/halfword reads.
- mem_do  output  32  read data.

Behaviour:
- Clocking and reset: one clock domain, clk. reset is synchronous and active-high.
- ALU (combinational; alu_b is the data operand for shifts):
  - 0000: A+B, wraps mod 2^32.
  - 0001: A-B, wraps mod 2^32.
  - 0010: A&B.
  - 0011: A|B.
  - 0100: A^B.
  - 0101: ~(A|B).
  - 0110: B << A[4:0] (logical).
  - 0111: B >> A[4:0] (logical).
  - 1000: B >>> A[4:0] (arithmetic).
  - 1001: signed A<B ? 1 : 0.
  - 1010: unsigned A<B ? 1 : 0.
  - 1011: pass A.
  - 1100: pass B.
  - 1101: B+8.
  - 1110 and 1111: output 0.
  - No carry or overflow outputs. Z and N always follow alu_out, including during reset.
- Adder: pc_plus4 = pc_in + 4, combinational, wraps at 2^32. Unaffected by reset.
- Memory storage:
  - Byte array named mem[0:MEM_BYTES-1], preloadable hierarchically with $readmemb/$readmemh.
  - Contents are NOT cleared by reset. Contents are X until written or preloaded.
- Byte ordering: big-endian. For a word access, mem[A] goes to bits 31:24, mem[A+1] to 23:16, mem[A+2] to 15:8, mem[A+3] to 7:0. Halfword: mem[A] to 15:8, mem[A+1] to 7:0.
- Addressing: no alignment requirement. A+k wraps modulo MEM_BYTES (e.g. a word at 511 uses bytes 511, 0, 1, 2).
- Read (mem_en=1, mem_rw=0, reset=0):
  - mem_do is combinational from mem_addr and the current contents.
  - Byte and halfword reads zero-extend when mem_se=0 and sign-extend when mem_se=1.
  - mem_se is ignored for word reads.
- mem_do = 0 in all other cases: mem_en=0, mem_rw=1, or reset=1.
- Write (mem_en=1, mem_rw=1, reset=0):
  - Applied at the rising edge of clk.
  - Byte stores mem_di[7:0]; halfword stores mem_di[15:0]; word stores all 32 bits, big-endian.
  - Bytes outside the access size are untouched.
- Reset: while reset=1 at a clock edge, writes are suppressed. Reset deasserting mid-sequence resumes normal operation on the next edge; there is no pipeline state.
- Read-after-write: a read of the same address in the cycle after a write returns the new data. There is no bypass within the same cycle.
- Latency:
  - ALU: 0 cycles.
  - Adder: 0 cycles.
  - Memory read: 0 cycles.
  - Memory write: visible after 1 edge.

Test Plan:
- ALU arithmetic and flags: A=5, B=5, op 0001 -> out 0, Z=1, N=0. A=3, B=5, op 0001 -> out 0xFFFFFFFE, Z=0, N=1. A=0xFFFFFFFF, B=1, op 0000 -> out 0, Z=1.
- ALU shifts, compares, pass-through:
  - A=4, B=0x80000000: op 0111 -> 0x08000000; op 1000 -> 0xF8000000; op 0110 -> 0.
  - A=0xFFFFFFFF, B=1: op 1001 -> 1; op 1010 -> 0.
  - B=100, op 1101 -> 108.
  - op 1111 -> 0.
- Adder: pc_in=0 -> 4. pc_in=0xFFFFFFFC -> 0.
- Word write then reads: write 0xA1B2C3D4 to addr 8 (size 10, en=1, rw=1, one edge), then read:
  - word @8 -> 0xA1B2C3D4.
  - byte @8, se=0 -> 0x000000A1.
  - byte @8, se=1 -> 0xFFFFFFA1.
  - halfword @10, se=1 -> 0xFFFFC3D4.
  - halfword @10, se=0 -> 0x0000C3D4.
- Partial write and wrap-around: byte write 0x5A to @9 leaves word @8 = 0xA15AC3D4. Word write 0x11223344 to @510 -> bytes 510=0x11, 511=0x22, 0=0x33, 1=0x44.
- Reset and enable gating: reset=1 with a write pending at @8 -> contents unchanged and mem_do=0. mem_en=0 -> mem_do=0 and no write. rw=1 -> mem_do=0.
